csi_crop: RTL and testbench
===========================

# csi_crop

Region-of-interest cropper between the CSI receiver's unpacked word stream and the ISP input, in the `csi_byte_clk` domain. It counts valid words per line and lines per frame, and forwards only the words inside a window fixed at elaboration time. It regenerates `in_line` and `in_frame` qualifiers for the cropped stream, so the ISP and `rgb2hdmi` see a smaller image with unchanged handshake semantics.

## Interface
Parameters:
- `X_START`, default 0: first forwarded word index in a line (0-based, counted on `dat_vld`).
- `X_LEN`, default 320: number of words forwarded per line; must be ≥1.
- `Y_START`, default 0: first forwarded line index in a frame (0-based).
- `Y_LEN`, default 480: number of lines forwarded per frame; must be ≥1.
- `CNT_W`, default 12: width of the word and line counters. Requires `X_START+X_LEN` < 2^CNT_W and `Y_START+Y_LEN` < 2^CNT_W.

Ports:
- `clk`, input, 1: CSI byte clock.
- `areset_n`, input, 1: asynchronous active-low reset.
- `in_dat`, input, `lane_data_t`: unpacked CSI word.
- `in_vld`, input, 1: `in_dat` valid this cycle.
- `in_line`, input, 1: high for the duration of a line.
- `in_frame`, input, 1: high for the duration of a frame.
- `out_dat`, output, `lane_data_t`: cropped word.
- `out_vld`, output, 1: `out_dat` valid.
- `out_line`, output, 1: high while the current word index and line are inside the window.
- `out_frame`, output, 1: `in_frame` delayed by 1 cycle, gated by the sync FSM.
- `crop_err`, output, 1: sticky flag; set when a windowed line ends before `X_START+X_LEN` words or a frame ends before `Y_START+Y_LEN` lines. Cleared at the next start of frame (SOF).

## Operation
- **Sync FSM states:**
  - `WAIT_GAP`: entered from reset. Waits for `in_frame`=0, then goes to `WAIT_SOF`.
  - `WAIT_SOF`: a rising edge of `in_frame` goes to `ACTIVE`.
  - `ACTIVE`: a falling edge of `in_frame` goes to `WAIT_SOF`.
  - Purpose: a partial frame present at reset release is never forwarded.
- **x_cnt (word counter):**
  - Cleared on the `in_line` rising edge.
  - Increments on each `in_vld` while `in_line`=1.
  - Saturates at all-ones.
- **y_cnt (line counter):**
  - Cleared on the `in_frame` rising edge.
  - Increments on each `in_line` falling edge while in `ACTIVE`.
  - Saturates at all-ones.
- **Window test:** uses the pre-increment values: `Y_START ≤ y_cnt < Y_START+Y_LEN` and `X_START ≤ x_cnt < X_START+X_LEN`. Counters are compared at CNT_W+1 bits to avoid overflow.
- **Forwarding:** `out_vld` = `in_vld` & `in_line` & `in_frame` & `ACTIVE` & in-window. `out_dat` loads only when `out_vld` is set and holds otherwise.
- **out_line:** high from the first in-window word through the last in-window word. It drops when `x_cnt` reaches `X_START+X_LEN` or when `in_line` falls, whichever comes first.
- **Ignored input:** `in_line` or `in_vld` outside `in_frame`.
- **Simultaneous events:**
  - `in_line` and `in_frame` falling in the same cycle: the line is counted, and the window check for short frames happens afterwards.
  - SOF and a line start in the same cycle: both counters start at 0.
- **Short lines/frames:** forwarded as-is (no padding). `crop_err` is set.

## Timing
- Reset value of every output is 0; the FSM resets to `WAIT_GAP`.
- All outputs are registered, with latency exactly 1 cycle from the input to `out_*`.
- There is no backpressure: the block accepts a word every cycle.
- Reset asserted mid-frame clears the outputs immediately (asynchronously). After release, nothing is forwarded until the next full frame.
- The first forwarded frame after reset is the first frame whose `in_frame` rising edge occurs in `WAIT_SOF`.

## Configuration
- **`CSI_CROP_STATS_EN` defined:** adds two outputs:
  - `stat_words` (CNT_W): last complete line's word count.
  - `stat_lines` (CNT_W): last complete frame's line count.
  - Both are captured at the `in_line` / `in_frame` falling edge and reset to 0. Used to bring up new sensor modes.
- **Not defined:** these ports and registers do not exist; `crop_err` is unaffected.

## Structure
- `lane_data_t` is used from `top_pkg`.
- Add the `crop_state_t` enum (`WAIT_GAP`, `WAIT_SOF`, `ACTIVE`) to `top_pkg`.
- Default window constants (`CROP_X_LEN`, `CROP_Y_LEN`) live in `top_pkg` so that `isp_top` `LINE_LENGTH` derives from the same value.
- No sub-module. An internal edge-detect for `in_line` / `in_frame` is inline logic.
- Instantiated in `top` between `u_csi_rx_top` and `u_isp`. Its `out_line` / `out_frame` replace `csi_in_line` / `csi_in_frame` downstream.

## Test plan
- **Nominal crop:** X_START=2, X_LEN=4, Y_START=1, Y_LEN=2; frame of 4 lines × 10 words with data = {line, word}.
  - Required: exactly 8 `out_vld` beats, data {1,2}…{1,5}, {2,2}…{2,5}.
  - Required: `out_line` high for 4 cycles per windowed line; `crop_err`=0.
- **Gaps:** same frame with `in_vld` toggling 0/1 inside lines → identical 8 words; `out_line` spans the gaps.
- **Reset mid-frame:** release `areset_n` during line 2 → no output for the rest of that frame; the next frame yields the full 8 words.
- **Short line:** windowed line 1 with 4 words (ends at word 3) → 2 words {1,2},{1,3} forwarded; `crop_err`=1 until the next SOF.
- **Short frame and simultaneous edges:** 2-line frame with the last `in_line` and `in_frame` falling in the same cycle → line 1 forwarded; `crop_err`=1; `out_frame` falls 1 cycle later.
- **Stats (CSI_CROP_STATS_EN):** 7 lines × 13 words → `stat_words`=13 after each line, `stat_lines`=7 after the frame.

Source files
------------

// File: rtl/top_pkg.sv
// ----------------------------------------------------------------------------
// top_pkg
// Shared types and constants for the CSI receive / ISP path.
//   lane_data_t  : one unpacked CSI word as delivered by the CSI receiver.
//   crop_state_t : sync state of csi_crop (frame-alignment after reset).
//   CROP_X_LEN / CROP_Y_LEN : default crop window size. isp_top derives its
//                  LINE_LENGTH from CROP_X_LEN so both stay consistent.
// ----------------------------------------------------------------------------
package top_pkg;

  typedef logic [15:0] lane_data_t;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,  // after reset: wait until in_frame is low
    WAIT_SOF = 2'd1,  // wait for a clean frame start
    ACTIVE   = 2'd2   // inside a frame that is being forwarded
  } crop_state_t;

  localparam int CROP_X_LEN = 320;
  localparam int CROP_Y_LEN = 480;

endpackage : top_pkg

// File: rtl/csi_crop.sv
// ----------------------------------------------------------------------------
// csi_crop
// Region-of-interest cropper on the unpacked CSI word stream (csi_byte_clk
// domain). Counts valid words per line and lines per frame and forwards only
// the words inside a window fixed by parameters. Line/frame qualifiers are
// regenerated for the cropped stream. All outputs are registered, 1 cycle
// latency, no backpressure.
//
// Ports:
//   clk, areset_n        : CSI byte clock, async active-low reset
//   in_dat/in_vld        : input word and its valid
//   in_line/in_frame     : input line / frame qualifiers
//   out_dat/out_vld      : cropped word (holds when not valid) and its valid
//   out_line/out_frame   : regenerated line / frame qualifiers
//   crop_err             : sticky short-line / short-frame flag, cleared at SOF
//   stat_words/stat_lines: (only with CSI_CROP_STATS_EN) word count of the last
//                          complete line, line count of the last complete frame
//
// Build option: define CSI_CROP_STATS_EN to add the stat_* outputs.
// ----------------------------------------------------------------------------
module csi_crop
  import top_pkg::*;
#(
  parameter int X_START = 0,
  parameter int X_LEN   = CROP_X_LEN,
  parameter int Y_START = 0,
  parameter int Y_LEN   = CROP_Y_LEN,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             areset_n,
  input  lane_data_t       in_dat,
  input  logic             in_vld,
  input  logic             in_line,
  input  logic             in_frame,
  output lane_data_t       out_dat,
  output logic             out_vld,
  output logic             out_line,
  output logic             out_frame,
  output logic             crop_err
`ifdef CSI_CROP_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_lines
`endif
);

  // Window bounds one bit wider than the counters so X_START+X_LEN cannot wrap.
  localparam logic [CNT_W:0] X_BEG = (CNT_W+1)'(X_START);
  localparam logic [CNT_W:0] X_END = (CNT_W+1)'(X_START + X_LEN);
  localparam logic [CNT_W:0] Y_BEG = (CNT_W+1)'(Y_START);
  localparam logic [CNT_W:0] Y_END = (CNT_W+1)'(Y_START + Y_LEN);

  crop_state_t      state_q;
  logic             line_q, frame_q;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  lane_data_t       out_dat_q;
  logic             out_vld_q, out_vld_d;
  logic             out_line_q, out_line_d;
  logic             out_frame_q, out_frame_d;
  logic             err_q, err_d;

  logic             line_rise, line_fall, frame_rise, frame_fall;
  logic             active, word, line_cnt, x_in, y_in;
  logic             short_line, short_frame;
  logic [CNT_W-1:0] x_cur, y_cur;

  // NOTE: every signal assigned in always_comb gets a default on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    line_rise  = in_line & ~line_q;
    // Only lines that ended inside a frame matter; in_line outside in_frame
    // is ignored.
    line_fall  = ~in_line & line_q & frame_q;
    frame_rise = in_frame & ~frame_q;
    frame_fall = ~in_frame & frame_q;

    // The SOF cycle itself already belongs to the forwarded frame, so a word
    // arriving together with the in_frame rising edge is not lost.
    active = (state_q == ACTIVE) || ((state_q == WAIT_SOF) && frame_rise);

    // Pre-increment indices of the current word / line. A rising edge
    // restarts the count at 0 in the same cycle.
    x_cur = line_rise  ? '0 : x_cnt_q;
    y_cur = frame_rise ? '0 : y_cnt_q;

    x_in = ({1'b0, x_cur} >= X_BEG) && ({1'b0, x_cur} < X_END);
    y_in = ({1'b0, y_cur} >= Y_BEG) && ({1'b0, y_cur} < Y_END);

    word    = in_vld & in_line & in_frame;
    x_cnt_d = x_cur;
    if (word && (x_cur != '1)) x_cnt_d = x_cur + CNT_W'(1);

    line_cnt = line_fall & active;
    y_cnt_d  = y_cur;
    if (line_cnt && (y_cur != '1)) y_cnt_d = y_cur + CNT_W'(1);

    out_vld_d = word & active & x_in & y_in;

    // Stretched from the first in-window word over any gaps until the word
    // count leaves the window or the line ends.
    out_line_d = out_vld_d |
                 (out_line_q & in_line & in_frame & active &
                  ({1'b0, x_cnt_d} < X_END));

    out_frame_d = in_frame & active;

    // Short frame uses the post-increment line count so a line ending in the
    // same cycle as the frame is included.
    short_line  = line_cnt & y_in & ({1'b0, x_cnt_q} < X_END);
    short_frame = frame_fall & (state_q == ACTIVE) & ({1'b0, y_cnt_d} < Y_END);

    err_d = frame_rise ? 1'b0 : (err_q | short_line | short_frame);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= WAIT_GAP;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      out_dat_q   <= '0;
      out_vld_q   <= 1'b0;
      out_line_q  <= 1'b0;
      out_frame_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        WAIT_GAP: if (!in_frame)  state_q <= WAIT_SOF;
        WAIT_SOF: if (frame_rise) state_q <= ACTIVE;
        ACTIVE:   if (frame_fall) state_q <= WAIT_SOF;
        default:                  state_q <= WAIT_GAP;
      endcase
      line_q      <= in_line;
      frame_q     <= in_frame;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      if (out_vld_d) out_dat_q <= in_dat;
      out_vld_q   <= out_vld_d;
      out_line_q  <= out_line_d;
      out_frame_q <= out_frame_d;
      err_q       <= err_d;
    end
  end

  assign out_dat   = out_dat_q;
  assign out_vld   = out_vld_q;
  assign out_line  = out_line_q;
  assign out_frame = out_frame_q;
  assign crop_err  = err_q;

`ifdef CSI_CROP_STATS_EN
  logic [CNT_W-1:0] stat_words_q, stat_lines_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      stat_words_q <= '0;
      stat_lines_q <= '0;
    end else begin
      if (line_cnt) stat_words_q <= x_cnt_q;
      if (frame_fall && (state_q == ACTIVE)) stat_lines_q <= y_cnt_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_lines = stat_lines_q;
`endif

endmodule : csi_crop

// File: tb/tb_csi_crop.sv
// ----------------------------------------------------------------------------
// tb_csi_crop
// Self-checking bench for csi_crop with a 2..5 x 1..2 window. Frames are
// described as lines of words; a frame builder turns each description into a
// cycle table of {inputs, expected outputs} using the window rules on the
// line/word indices it generates, and a player applies the table and compares
// one cycle later. Hand-written sequences cover reset and crop_err.
// ----------------------------------------------------------------------------
module tb_csi_crop;
  import top_pkg::*;

  localparam int XS = 2;
  localparam int XL = 4;
  localparam int YS = 1;
  localparam int YL = 2;
  localparam int CW = 12;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  lane_data_t in_dat = '0;
  logic       in_vld = 1'b0, in_line = 1'b0, in_frame = 1'b0;
  lane_data_t out_dat;
  logic       out_vld, out_line, out_frame, crop_err;
`ifdef CSI_CROP_STATS_EN
  logic [CW-1:0] stat_words, stat_lines;
`endif

  always #5 clk = ~clk;

  csi_crop #(
    .X_START(XS), .X_LEN(XL), .Y_START(YS), .Y_LEN(YL), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_dat    (in_dat),
    .in_vld    (in_vld),
    .in_line   (in_line),
    .in_frame  (in_frame),
    .out_dat   (out_dat),
    .out_vld   (out_vld),
    .out_line  (out_line),
    .out_frame (out_frame),
    .crop_err  (crop_err)
`ifdef CSI_CROP_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_lines(stat_lines)
`endif
  );

  typedef struct {
    logic       frame, line, vld;
    lane_data_t dat;
    logic       e_vld, e_line, e_frame;
    lane_data_t e_dat;
  } vec_t;

  vec_t       tbl[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         beats;
  int         exp_beats;
  int         line2_idx;
  lane_data_t exp_dat = '0;
  int         wpl[8];
  bit         exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add_vec(input logic f, input logic l, input logic v, input lane_data_t d,
                         input logic ev, input logic el, input logic ef);
    vec_t t;
    t.frame = f; t.line = l; t.vld = v; t.dat = d;
    t.e_vld = ev; t.e_line = el; t.e_frame = ef; t.e_dat = d;
    tbl.push_back(t);
  endtask

  // Builds a frame of nlines lines with w[j] words each. Expected outputs
  // follow from the window on (line j, word k); err from the short rules.
  task automatic build_frame(input int nlines, input int w[8], input bit gaps,
                             input bit fwd, input bit same_edge, output bit err);
    bit win_row, line_on, win;
    err = fwd && (nlines < YS + YL);
    add_vec(0, 0, 0, '0, 0, 0, 0);
    add_vec(0, 0, 0, '0, 0, 0, 0);
    add_vec(1, 0, 0, '0, 0, 0, fwd);  // SOF
    for (int j = 0; j < nlines; j++) begin
      if (j == 2) line2_idx = tbl.size();
      add_vec(1, 0, 0, '0, 0, 0, fwd);
      win_row = fwd && (j >= YS) && (j < YS + YL);
      if (win_row && (w[j] < XS + XL)) err = 1'b1;
      line_on = 1'b0;
      for (int k = 0; k < w[j]; k++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) add_vec(1, 1, 0, '0, 0, line_on, fwd);
        win = win_row && (k >= XS) && (k < XS + XL);
        if (win && (k == XS)) line_on = 1'b1;
        add_vec(1, 1, 1, {8'(j), 8'(k)}, win, line_on, fwd);
        if (k == XS + XL - 1) line_on = 1'b0;
      end
      if (same_edge && (j == nlines - 1)) add_vec(0, 0, 0, '0, 0, 0, 0);
      else                                add_vec(1, 0, 0, '0, 0, 0, fwd);
    end
    if (!same_edge) add_vec(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      in_frame = tbl[i].frame; in_line = tbl[i].line;
      in_vld   = tbl[i].vld;   in_dat  = tbl[i].dat;
      @(posedge clk);
      #1;
      if (tbl[i].e_vld) begin
        exp_dat = tbl[i].e_dat;
        exp_beats++;
      end
      if (out_vld === 1'b1) beats++;
      check("out_vld",   out_vld,   tbl[i].e_vld);
      check("out_line",  out_line,  tbl[i].e_line);
      check("out_frame", out_frame, tbl[i].e_frame);
      check("out_dat",   out_dat,   exp_dat);
    end
  endtask

  task automatic run_frame(input int nlines, input bit gaps, input bit same_edge);
    tbl.delete();
    beats = 0; exp_beats = 0;
    build_frame(nlines, wpl, gaps, 1'b1, same_edge, exp_err);
    play(0, tbl.size());
    check("beats", beats, exp_beats);
    check("crop_err", crop_err, exp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_frame = 0; in_line = 0; in_vld = 0; in_dat = '0;
    end
  endtask

  initial begin
    // Reset state, observed while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst out_vld",   out_vld,   1'b0);
    check("rst out_line",  out_line,  1'b0);
    check("rst out_frame", out_frame, 1'b0);
    check("rst out_dat",   out_dat,   16'h0);
    check("rst crop_err",  crop_err,  1'b0);
`ifdef CSI_CROP_STATS_EN
    check("rst stat_words", stat_words, 0);
    check("rst stat_lines", stat_lines, 0);
`endif
    @(negedge clk);
    areset_n = 1'b1;

    // Nominal crop: 4 lines x 10 words.
    foreach (wpl[i]) wpl[i] = 10;
    run_frame(4, 1'b0, 1'b0);
    check("nominal beats", beats, 8);
    check("nominal last dat", out_dat, 16'h0205);

    // Same frame with gaps inside lines.
    run_frame(4, 1'b1, 1'b0);
    check("gaps beats", beats, 8);

    // Short windowed line 1 (4 words): 2 words from it, sticky error.
    wpl[1] = 4;
    run_frame(4, 1'b0, 1'b0);
    check("short line beats", beats, 6);
    check("short line err", crop_err, 1'b1);
    idle(5);
    #1;
    check("err sticky", crop_err, 1'b1);
    wpl[1] = 10;
    run_frame(4, 1'b0, 1'b0);
    check("err cleared", crop_err, 1'b0);

    // Short frame with last line and frame falling together.
    run_frame(2, 1'b0, 1'b1);
    check("short frame beats", beats, 4);
    check("short frame err", crop_err, 1'b1);

    // Reset asserted and released during line 2: rest of frame suppressed.
    tbl.delete();
    beats = 0; exp_beats = 0;
    build_frame(4, wpl, 1'b0, 1'b1, 1'b0, exp_err);
    play(0, line2_idx + 3);
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    check("async rst vld",   out_vld,   1'b0);
    check("async rst frame", out_frame, 1'b0);
    check("async rst dat",   out_dat,   16'h0);
    check("async rst err",   crop_err,  1'b0);
    exp_dat = '0;
    @(negedge clk);
    areset_n = 1'b1;
    for (int i = line2_idx + 3; i < tbl.size(); i++) begin
      tbl[i].e_vld = 1'b0; tbl[i].e_line = 1'b0; tbl[i].e_frame = 1'b0;
    end
    play(line2_idx + 3, tbl.size());
    check("post-rst beats", beats, exp_beats);
    run_frame(4, 1'b0, 1'b0);
    check("after rst beats", beats, 8);

    // Randomized frames against the frame model.
    for (int f = 0; f < 8; f++) begin
      foreach (wpl[i]) wpl[i] = $urandom_range(1, 10);
      run_frame($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef CSI_CROP_STATS_EN
    // 7 lines x 13 words; exercises the line-count register beyond 4 lines.
    tbl.delete();
    beats = 0; exp_beats = 0;
    begin
      int w13[8];
      foreach (w13[i]) w13[i] = 13;
      build_frame(7, w13, 1'b0, 1'b1, 1'b0, exp_err);
    end
    play(0, tbl.size());
    check("stats beats", beats, exp_beats);
    check("stat_words", stat_words, 13);
    check("stat_lines", stat_lines, 7);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_csi_crop
